// File: rtl/lif_sequencer_if.sv
// ----------------------------------------------------------------------------
// lif_sequencer_if
// Input-current channel of the LIF sequencer (valid/ready handshake).
//   in_valid   : a current word is offered
//   in_ready   : the sequencer can take the word this cycle
//   in_idx     : target neuron (0..3)
//   in_current : unsigned current to add to that neuron's pending accumulator
// master = current source, slave = sequencer.
// ----------------------------------------------------------------------------
interface lif_sequencer_if;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] in_idx;
   logic [7:0] in_current;

   modport master (
      output in_valid,
      output in_idx,
      output in_current,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_idx,
      input  in_current,
      output in_ready
   );
endinterface

// File: rtl/lif_sequencer.sv
// ----------------------------------------------------------------------------
// lif_sequencer
// Four leaky integrate-and-fire neurons sharing one update datapath. Input
// currents accumulate into per-neuron pending registers while idle; a tick
// starts a sweep that updates neurons 0..3 on four consecutive edges and then
// publishes all four spike bits together.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   tick         : start one update sweep (ignored while busy, sets overrun)
//   in_bus       : input-current handshake channel (slave side)
//   cfg_we       : threshold write strobe (honoured only while idle)
//   cfg_thresh   : new threshold value
//   spikes       : spike bits of the last completed sweep
//   done         : one-cycle pulse after a sweep completes
//   busy         : sweep in progress
//   overrun      : sticky, a tick arrived while busy
// ----------------------------------------------------------------------------
module lif_sequencer #(
   parameter logic [7:0] THRESH_INIT = 8'd32,
   parameter int         REFRAC      = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  tick,
   lif_sequencer_if.slave        in_bus,
   input  logic                  cfg_we,
   input  logic [7:0]            cfg_thresh,
   output logic [3:0]            spikes,
   output logic                  done,
   output logic                  busy,
   output logic                  overrun
);

   typedef enum logic {IDLE, UPDATE} state_t;

   localparam logic [1:0] REFRAC_LOAD = 2'(REFRAC);

   state_t     state;
   state_t     state_next;
   logic [1:0] idx;
   logic [7:0] mem   [4];
   logic [7:0] pend  [4];
   logic [1:0] refr  [4];
   logic [7:0] threshold;
   logic [3:0] sweep_bits;

   logic [8:0] acc_sum;
   logic [7:0] acc_sat;
   logic [8:0] upd_sum;
   logic [7:0] upd_next;
   logic       in_refrac;
   logic       fire;
   logic [3:0] bits_next;

   // Shared arithmetic: saturating accumulate for the input channel and the
   // leak-plus-integrate step for the neuron currently selected by idx.
   // bits_next merges this neuron's result into the sweep so the final edge
   // can publish all four bits at once.
   always_comb begin
      acc_sum   = {1'b0, pend[in_bus.in_idx]} + {1'b0, in_bus.in_current};
      acc_sat   = acc_sum[8] ? 8'hFF : acc_sum[7:0];
      upd_sum   = {1'b0, pend[idx]} + {2'b00, mem[idx][7:1]};
      upd_next  = upd_sum[8] ? 8'hFF : upd_sum[7:0];
      in_refrac = (refr[idx] != 2'd0);
      fire      = !in_refrac && (upd_next >= threshold);
      bits_next = sweep_bits;
      bits_next[idx] = fire;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next state: a sweep always lasts exactly four edges.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (tick) state_next = UPDATE;
         UPDATE:  if (idx == 2'd3) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Handshake/status outputs decoded from the state.
   always_comb begin
      busy            = (state == UPDATE);
      in_bus.in_ready = (state == IDLE);
   end

   // Neuron storage, threshold and sweep bookkeeping. Inputs and config are
   // only taken while idle, so they never collide with a neuron update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx        <= 2'd0;
         threshold  <= THRESH_INIT;
         sweep_bits <= 4'd0;
         spikes     <= 4'd0;
         done       <= 1'b0;
         overrun    <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            mem[i]  <= 8'd0;
            pend[i] <= 8'd0;
            refr[i] <= 2'd0;
         end
      end else begin
         done <= 1'b0;
         if (tick && state == UPDATE) overrun <= 1'b1;
         case (state)
            IDLE: begin
               idx <= 2'd0;
               if (in_bus.in_valid) pend[in_bus.in_idx] <= acc_sat;
               if (cfg_we) threshold <= cfg_thresh;
            end
            UPDATE: begin
               pend[idx] <= 8'd0;
               if (in_refrac) begin
                  mem[idx]  <= 8'd0;
                  refr[idx] <= refr[idx] - 2'd1;
               end else if (fire) begin
                  mem[idx]  <= 8'd0;
                  refr[idx] <= REFRAC_LOAD;
               end else begin
                  mem[idx]  <= upd_next;
               end
               sweep_bits <= bits_next;
               idx        <= idx + 2'd1;
               if (idx == 2'd3) begin
                  spikes <= bits_next;
                  done   <= 1'b1;
               end
            end
            default: idx <= 2'd0;
         endcase
      end
   end

endmodule
